// File: rtl/alb_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alb_wide_sequencer
// Brief    : Time-shares one ALB slice to execute wide ADD/SUB/AND/OR, one slice
//            per clock, LSB first, chaining slice carry-out into the next CI.
// Revision : 1.0 - initial release
// ============================================================================
module alb_wide_sequencer #(
  parameter int SLICE_W = 4,
  parameter int SLICES  = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic [2:0]                OP,
  input  logic [SLICE_W*SLICES-1:0] A,
  input  logic [SLICE_W*SLICES-1:0] B,
  input  logic                      CIN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic [SLICE_W*SLICES-1:0] RESULT,
  output logic                      CO_OUT,
  output logic                      VO_OUT,
  output logic                      NO_OUT,
  output logic                      ZO_OUT,
  output logic [SLICE_W-1:0]        MR,
  output logic [SLICE_W-1:0]        MS,
  output logic                      CI,
  output logic [2:0]                ALB_MI,
  input  logic [SLICE_W-1:0]        F_ALB,
  input  logic                      CO,
  input  logic                      VO,
  input  logic                      NO,
  input  logic                      ZO
);

  localparam int              c_w      = SLICE_W * SLICES;
  localparam int              c_kw     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [c_kw-1:0] c_k_last = c_kw'(SLICES - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_fail = 2'd2;

  localparam logic [2:0] c_op_sub = 3'b000;
  localparam logic [2:0] c_op_add = 3'b011;

  logic [1:0]      r_state;
  logic [c_kw-1:0] r_k;
  logic [c_w-1:0]  r_a;
  logic [c_w-1:0]  r_b;
  logic [2:0]      r_op;
  logic            r_cin;
  logic            r_carry;
  logic            r_zacc;
  logic [c_w-1:0]  r_acc;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [c_w-1:0]  r_result;
  logic            r_co;
  logic            r_vo;
  logic            r_no;
  logic            r_zo;

  logic            w_arith;
  logic            w_exec;
  logic [c_w-1:0]  w_final;

  assign w_arith = (r_op == c_op_sub) || (r_op == c_op_add);
  assign w_exec  = (r_state == c_st_exec);

  // The ALB is only driven while a slice is executing; otherwise it sees zeros.
  always_comb begin
    MR = '0;
    MS = '0;
    CI = 1'b0;
    if (w_exec) begin
      MR = r_a[r_k*SLICE_W +: SLICE_W];
      MS = r_b[r_k*SLICE_W +: SLICE_W];
      CI = w_arith & ((r_k == '0) ? r_cin : r_carry);
    end
  end

  // Accumulator with the current slice's ALB result merged in.
  always_comb begin
    w_final = r_acc;
    w_final[r_k*SLICE_W +: SLICE_W] = F_ALB;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= c_st_idle;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 3'b000;
      r_cin    <= 1'b0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_co     <= 1'b0;
      r_vo     <= 1'b0;
      r_no     <= 1'b0;
      r_zo     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= OP;
            r_cin   <= CIN;
            r_k     <= '0;
            r_zacc  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= OP[2] ? c_st_fail : c_st_exec;
          end
        end
        c_st_exec: begin
          r_acc   <= w_final;
          r_carry <= CO;
          r_zacc  <= r_zacc & ZO;
          if (r_k == c_k_last) begin
            r_result <= w_final;
            r_co     <= w_arith & CO;
            r_vo     <= w_arith & VO;
            r_no     <= NO;
            r_zo     <= r_zacc & ZO;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= c_st_idle;
          end else begin
            r_k <= r_k + c_kw'(1);
          end
        end
        c_st_fail: begin
          r_result <= '0;
          r_co     <= 1'b0;
          r_vo     <= 1'b0;
          r_no     <= 1'b0;
          r_zo     <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= c_st_idle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign ERR    = r_err;
  assign RESULT = r_result;
  assign CO_OUT = r_co;
  assign VO_OUT = r_vo;
  assign NO_OUT = r_no;
  assign ZO_OUT = r_zo;
  assign ALB_MI = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alb_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alb_wide_sequencer
// Brief    : Scoreboard bench for alb_wide_sequencer with a behavioural ALB slice
//            and an arithmetic reference model of the wide operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alb_wide_sequencer;

  localparam int SW = 4;
  localparam int NS = 2;
  localparam int W  = SW * NS;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op    = 3'b000;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          cin   = 1'b0;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic          co_out, vo_out, no_out, zo_out;
  logic [SW-1:0] mr, ms, f_alb;
  logic          ci;
  logic [2:0]    alb_mi;
  logic          co, vo, no, zo;
  logic [SW:0]   alb_sum;

  alb_wide_sequencer #(.SLICE_W(SW), .SLICES(NS)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .OP(op), .A(a), .B(b), .CIN(cin),
    .BUSY(busy), .DONE(done), .ERR(err), .RESULT(result),
    .CO_OUT(co_out), .VO_OUT(vo_out), .NO_OUT(no_out), .ZO_OUT(zo_out),
    .MR(mr), .MS(ms), .CI(ci), .ALB_MI(alb_mi),
    .F_ALB(f_alb), .CO(co), .VO(vo), .NO(no), .ZO(zo)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALB slice; SUB is MR + ~MS + CI.
  always_comb begin
    alb_sum = '0;
    vo      = 1'b0;
    case (alb_mi)
      OP_ADD: begin
        alb_sum = {1'b0, mr} + {1'b0, ms} + {{SW{1'b0}}, ci};
        vo      = (mr[SW-1] == ms[SW-1]) && (alb_sum[SW-1] != mr[SW-1]);
      end
      OP_SUB: begin
        alb_sum = {1'b0, mr} + {1'b0, ~ms} + {{SW{1'b0}}, ci};
        vo      = (mr[SW-1] != ms[SW-1]) && (alb_sum[SW-1] != mr[SW-1]);
      end
      OP_AND:  alb_sum = {1'b0, mr & ms};
      OP_OR:   alb_sum = {1'b0, mr | ms};
      default: alb_sum = '0;
    endcase
    f_alb = alb_sum[SW-1:0];
    co    = alb_sum[SW];
    no    = f_alb[SW-1];
    zo    = (f_alb == '0);
  end

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;   // {CO, VO, NO, ZO}
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc        = 0;
  int           n_cmp      = 0;
  int           n_bad      = 0;
  int           free_cyc   = 0;
  int           acc_cyc    = -100;
  logic [2:0]   infl_op    = 3'b000;
  logic [2:0]   prev_mi    = 3'b000;
  logic [W-1:0] infl_a     = '0;
  logic [W-1:0] infl_b     = '0;
  logic         infl_cin   = 1'b0;
  logic [W-1:0] hold_res   = '0;
  logic [3:0]   hold_flags = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int done_at);
    exp_t e;
    int   full, ux, uy, sx, sy, s, ss;
    logic arith, eco, evo;
    full  = 1 << W;
    ux    = int'(x);
    uy    = int'(y);
    sx    = (ux >= full / 2) ? ux - full : ux;
    sy    = (uy >= full / 2) ? uy - full : uy;
    arith = (o == OP_ADD) || (o == OP_SUB);
    s     = 0;
    ss    = 0;
    case (o)
      OP_ADD: begin s = ux + uy + int'(c);            ss = sx + sy + int'(c); end
      OP_SUB: begin s = ux + (full - 1 - uy) + int'(c); ss = sx - sy - 1 + int'(c); end
      OP_AND: s = ux & uy;
      OP_OR:  s = ux | uy;
      default: s = 0;
    endcase
    eco     = arith && (s >= full);
    evo     = arith && ((ss > full / 2 - 1) || (ss < -(full / 2)));
    e.err   = o[2];
    e.cyc   = done_at;
    e.res   = o[2] ? '0 : s[W-1:0];
    e.flags = o[2] ? 4'b0000 : {eco, evo, e.res[W-1], (e.res == '0)};
    return e;
  endfunction

  // Carry entering slice k: the carry out of the low k slices of the wide sum.
  function automatic logic carry_in(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c, input int k);
    int m, s;
    m = (1 << (SW * k)) - 1;
    if (o == OP_ADD) s = (int'(x) & m) + (int'(y) & m) + int'(c);
    else             s = (int'(x) & m) + ((~int'(y)) & m) + int'(c);
    return s[SW*k];
  endfunction

  // Monitor: output handshake, held values and ALB drive, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t          e;
    int            k;
    logic [SW-1:0] emr, ems;
    logic          eci;
    check("busy", 32'(busy), 32'((cyc > acc_cyc) && (cyc < free_cyc)));
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("result", 32'(result), 32'(e.res));
        check("flags_cvnz", 32'({co_out, vo_out, no_out, zo_out}), 32'(e.flags));
        check("err", 32'(err), 32'(e.err));
        hold_res   = e.res;
        hold_flags = e.flags;
      end
    end else begin
      check("err_idle", 32'(err), 32'd0);
      check("result_hold", 32'(result), 32'(hold_res));
      check("flags_hold", 32'({co_out, vo_out, no_out, zo_out}), 32'(hold_flags));
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        check("done_missing", 32'(done), 32'd1);
        e = sb.pop_front();
      end
    end
    emr = '0;
    ems = '0;
    eci = 1'b0;
    k   = cyc - acc_cyc - 1;
    if (!infl_op[2] && k >= 0 && k < NS) begin
      emr = infl_a[k*SW +: SW];
      ems = infl_b[k*SW +: SW];
      if (infl_op == OP_ADD || infl_op == OP_SUB)
        eci = carry_in(infl_op, infl_a, infl_b, infl_cin, k);
    end
    check("mr", 32'(mr), 32'(emr));
    check("ms", 32'(ms), 32'(ems));
    check("ci", 32'(ci), 32'(eci));
    check("alb_mi", 32'(alb_mi), 32'((cyc > acc_cyc) ? infl_op : prev_mi));
  end

  // One clock of stimulus; an accepted START pushes its expected completion.
  task automatic step(input logic s, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c);
    int done_at;
    start = s;
    op    = o;
    a     = x;
    b     = y;
    cin   = c;
    if (s && rst_n && cyc >= free_cyc) begin
      done_at = o[2] ? cyc + 2 : cyc + NS + 1;
      sb.push_back(model(o, x, y, c, done_at));
      prev_mi  = infl_op;
      infl_op  = o;
      infl_a   = x;
      infl_b   = y;
      infl_cin = c;
      acc_cyc  = cyc;
      free_cyc = done_at;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    step(1'b1, o, x, y, c);
    for (int i = 0; i < 20 && cyc < free_cyc; i++) step(1'b0, o, x, y, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alb_mi", 32'(alb_mi), 32'd0);
    rst_n = 1'b1;

    run(OP_ADD, 8'h6F, 8'h01, 1'b0);
    run(OP_ADD, 8'hFF, 8'h01, 1'b1);
    run(OP_ADD, 8'h7F, 8'h01, 1'b0);
    run(OP_SUB, 8'h10, 8'h01, 1'b1);
    run(OP_SUB, 8'h55, 8'h55, 1'b1);
    run(OP_AND, 8'hC6, 8'h3F, 1'b1);
    run(OP_OR,  8'hC6, 8'h3F, 1'b1);

    // START held through BUSY, then an illegal op issued in the DONE cycle.
    step(1'b1, OP_ADD, 8'h12, 8'h34, 1'b0);
    repeat (NS) step(1'b1, OP_ADD, 8'h12, 8'h34, 1'b0);
    run(3'b101, 8'hAA, 8'h55, 1'b0);

    // Reset pulsed during the last slice cycle aborts the operation.
    step(1'b1, OP_ADD, 8'h3C, 8'h4D, 1'b0);
    step(1'b0, OP_ADD, 8'h3C, 8'h4D, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_mr_ms", 32'({mr, ms}), 32'd0);
    sb.delete();
    acc_cyc    = -100;
    free_cyc   = cyc;
    prev_mi    = 3'b000;
    infl_op    = 3'b000;
    hold_res   = '0;
    hold_flags = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (NS + 2) step(1'b0, OP_ADD, '0, '0, 1'b0);

    repeat (400) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      step(($urandom_range(0, 2) != 0), ro, W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (NS + 3) step(1'b0, OP_ADD, '0, '0, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
